div_period_meter: RTL

//  Receive-side counterpart of the loadable 8-bit frequency divider. Measures the

---
 rtl/div_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/div_period_meter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the loadable frequency divider and its receive-side period meter.
// The state encoding and counter limit are reused by the divider benches.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic {
    IDLE,
    MEASURE
  } meas_state_e;

  // Largest value held by a WIDTH+1 bit period counter.
  function automatic int MAX_CNT(input int width);
    return (1 << (width + 1)) - 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous pulse train into the clock_oscillator domain.
// Emits a registered single-cycle pulse on each synchronized rising edge.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_oscillator,
  input  logic pin_name1,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // The rise pulse is registered so downstream logic sees a clean, glitch-free strobe.
  always_ff @(posedge clock_oscillator) begin
    if (pin_name1) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/div_period_meter.sv
// Measures the rising-edge period of a divided pulse train and recovers the divisor
// preload value (2^WIDTH - period), with lock, range and timeout status.
module div_period_meter
  import div_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 2
) (
  input  logic             clock_oscillator,
  input  logic             pin_name1,
  input  logic             sig_in,
  output logic [WIDTH:0]   period,
  output logic [WIDTH-1:0] divisor,
  output logic             meas_valid,
  output logic             locked,
  output logic             range_err,
  output logic             timeout
);

  localparam int             W1          = WIDTH + 1;
  localparam logic [WIDTH:0] CNT_MAX     = W1'(MAX_CNT(WIDTH));
  localparam logic [WIDTH:0] CNT_FULL    = {1'b1, {WIDTH{1'b0}}};
  localparam logic [2:0]     LOCK_THRESH = 3'(LOCK_COUNT - 1);

  logic sig_rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clock_oscillator(clock_oscillator),
    .pin_name1       (pin_name1),
    .d               (sig_in),
    .rise            (sig_rise)
  );

  meas_state_e      state_q;
  logic [WIDTH:0]   cnt_q;
  logic [WIDTH:0]   period_q;
  logic [WIDTH-1:0] divisor_q;
  logic             meas_valid_q;
  logic             locked_q;
  logic             range_err_q;
  logic             timeout_q;
  logic [2:0]       run_q;

  logic       in_range;
  logic       same_period;
  logic [2:0] run_inc;

  assign in_range    = (cnt_q != '0) && (cnt_q <= CNT_FULL);
  assign same_period = (cnt_q == period_q);
  assign run_inc     = (run_q == 3'd7) ? run_q : run_q + 3'd1;

  // An edge in MEASURE always closes the current period, even when the counter
  // has just saturated, so edge handling takes priority over the timeout path.
  always_ff @(posedge clock_oscillator) begin
    if (pin_name1) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      divisor_q    <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      range_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      run_q        <= '0;
    end else begin
      meas_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sig_rise) begin
            cnt_q     <= W1'(1);
            timeout_q <= 1'b0;
            state_q   <= MEASURE;
          end
        end
        MEASURE: begin
          if (sig_rise) begin
            meas_valid_q <= 1'b1;
            period_q     <= cnt_q;
            cnt_q        <= W1'(1);
            timeout_q    <= 1'b0;
            if (in_range) begin
              divisor_q   <= WIDTH'(CNT_FULL - cnt_q);
              range_err_q <= 1'b0;
              if (same_period) begin
                run_q    <= run_inc;
                locked_q <= (run_inc >= LOCK_THRESH);
              end else begin
                run_q    <= '0;
                locked_q <= 1'b0;
              end
            end else begin
              divisor_q   <= '0;
              range_err_q <= 1'b1;
              run_q       <= '0;
              locked_q    <= 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            run_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + W1'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period     = period_q;
  assign divisor    = divisor_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign range_err  = range_err_q;
  assign timeout    = timeout_q;

endmodule
